// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 2604;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Result of a stop-bit sample, passed from the FSM to the holding register.
  typedef struct packed {
    logic       deliver;
    logic       ferr;
    logic [7:0] byte_val;
  } rx_event_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte stream from the receiver to its consumer: valid/ready data plus line status.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/sync_fall_det.sv
// Two-flop synchroniser for the asynchronous serial line plus a delay flop for
// falling-edge detection. All flops reset high so an idle line never looks like a start edge.
module sync_fall_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout_s,
  output logic fall
);

  logic meta_reg;
  logic rxd_s_reg;
  logic rxd_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg     <= 1'b1;
      rxd_s_reg    <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      meta_reg     <= din;
      rxd_s_reg    <= meta_reg;
      rxd_prev_reg <= rxd_s_reg;
    end
  end

  assign dout_s = rxd_s_reg;
  assign fall   = rxd_prev_reg & ~rxd_s_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge qualified bit FSM feeding a single-entry
// valid/ready holding register, with the last delivered byte mirrored on the LEDs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic        ftdi_rxd,
  uart_rx_if.master   rx_bus,
  output logic [7:0]  led
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic rxd_s;
  logic fall;

  sync_fall_det u_sync (
    .clk    (clk_25mhz),
    .reset  (reset),
    .din    (ftdi_rxd),
    .dout_s (rxd_s),
    .fall   (fall)
  );

  uart_state_t      state_reg,   state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shreg_reg,   shreg_next;
  rx_event_t        evt;

  logic [7:0] rx_data_reg,   rx_data_next;
  logic [7:0] led_reg,       led_next;
  logic       rx_valid_reg,  rx_valid_next;
  logic       frame_err_reg, frame_err_next;
  logic       overrun_reg,   overrun_next;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shreg_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shreg_reg   <= shreg_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg + 1'b1;
    bit_idx_next = bit_idx_reg;
    shreg_next   = shreg_reg;
    evt          = '{deliver: 1'b0, ferr: 1'b0, byte_val: shreg_reg};

    case (state_reg)
      IDLE: begin
        // Only a fresh high-to-low edge starts a frame, so a held-low line stays idle.
        bit_cnt_next = '0;
        if (fall) begin
          state_next = START;
        end
      end

      START: begin
        if (bit_cnt_reg == HALF_LAST) begin
          if (rxd_s) begin
            state_next = IDLE;
          end else begin
            state_next   = DATA;
            bit_cnt_next = '0;
            bit_idx_next = '0;
          end
        end
      end

      DATA: begin
        if (bit_cnt_reg == BIT_LAST) begin
          shreg_next   = {rxd_s, shreg_reg[7:1]};
          bit_cnt_next = '0;
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        if (bit_cnt_reg == BIT_LAST) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
          if (rxd_s) begin
            evt.deliver = 1'b1;
          end else begin
            evt.ferr = 1'b1;
          end
        end
      end

      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    rx_data_next   = rx_data_reg;
    led_next       = led_reg;
    rx_valid_next  = rx_valid_reg;
    overrun_next   = overrun_reg;
    frame_err_next = evt.ferr;

    // A consume and a new delivery in the same cycle hand over without a bubble.
    if (evt.deliver) begin
      if (!rx_valid_reg || rx_bus.rx_ready) begin
        rx_data_next  = evt.byte_val;
        led_next      = evt.byte_val;
        rx_valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (rx_valid_reg && rx_bus.rx_ready) begin
      rx_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      rx_data_reg   <= '0;
      led_reg       <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      rx_data_reg   <= rx_data_next;
      led_reg       <= led_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign rx_bus.rx_data   = rx_data_reg;
  assign rx_bus.rx_valid  = rx_valid_reg;
  assign rx_bus.frame_err = frame_err_reg;
  assign rx_bus.overrun   = overrun_reg;
  assign led              = led_reg;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the ULX3S FTDI serial link: the consumer-side counterpart of the board's 8N1 transmitter. It samples `ftdi_rxd` at 25 MHz and recovers 8N1 bytes at the same bit period the transmitter uses (2604 clocks/bit). Each byte is delivered through a single-entry valid/ready holding register, and the last good byte is mirrored on the board LEDs. It sits between the FTDI pin and whatever command or loopback logic consumes host bytes.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 2604: clocks per UART bit; must be ≥ 4.
- `HALF_BIT`, default `CLKS_PER_BIT/2` (1302): delay from the detected start edge to the start-bit mid-sample.

Ports:
- `clk_25mhz`  in  1  system clock, 25 MHz.
- `reset`  in  1  reset; synchronous, active-high.
- `ftdi_rxd`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `overrun`  out  1  sticky; set when a byte is lost; cleared only by `reset`.
- `led`  out  8  last delivered byte.

## Operation
- **Input synchronisation**
  - `ftdi_rxd` passes through a 2-flop synchroniser, then a third flop `rxd_prev`.
  - `fall` = `rxd_prev & ~rxd_s`.
- **FSM states:** `IDLE`, `START`, `DATA`, `STOP`. Counters:
  - `bit_cnt`: clock counter, width `$clog2(CLKS_PER_BIT)+1`.
  - `bit_idx`: 3-bit data-bit index.
- **Transitions**
  - `IDLE`: on `fall` go to `START`; `bit_cnt`←0.
  - `START`: at `bit_cnt == HALF_BIT-1`, sample `rxd_s`.
    - 1 (glitch): go to `IDLE`; nothing reported.
    - 0: go to `DATA`; `bit_cnt`←0; `bit_idx`←0.
  - `DATA`: at `bit_cnt == CLKS_PER_BIT-1`:
    - shift `rxd_s` into `shreg[7]`, shifting right (LSB first);
    - `bit_cnt`←0; increment `bit_idx`;
    - after the sample with `bit_idx==7`, go to `STOP`.
  - `STOP`: at `bit_cnt == CLKS_PER_BIT-1`, sample `rxd_s` and go to `IDLE`.
    - 1: deliver `shreg`.
    - 0: pulse `frame_err` for that cycle; byte discarded.
- **Framing-error recovery:** `IDLE` needs a fresh high→low edge, so a held-low (break) line never retriggers.
- **Delivery** (registered; visible the cycle after the stop sample):
  - `rx_valid`=0, or `rx_valid && rx_ready` in that cycle: load `rx_data`←`shreg`, `led`←`shreg`, `rx_valid`←1.
  - `rx_valid`=1 and `rx_ready`=0: new byte dropped, `overrun`←1, old byte retained.
- **Consumption:** `rx_valid && rx_ready` with no delivery that cycle → `rx_valid`←0.
- **Reset values** (reset wins over all events, including mid-byte):
  - FSM = `IDLE`; counters 0; synchroniser flops 1.
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `led`=0.
  - A byte in flight at reset is abandoned.

## Timing
- Pin to `fall` asserted: 3 clocks (2 synchroniser + `rxd_prev`).
- Data bit k sampled `HALF_BIT + (k+1)·CLKS_PER_BIT` clocks after `START` entry (mid-bit).
- Stop-bit sample: `HALF_BIT + 9·CLKS_PER_BIT` clocks after `START` entry.
- `rx_valid` / `frame_err` assert 1 clock after the stop sample.
- End-to-end at defaults: about 24741 clocks (±1) from the pin falling edge to `rx_valid`.
- Back-to-back frames: the earliest next start edge arrives about `HALF_BIT` after the stop sample. `IDLE` is re-entered first, so no frame is missed.
- `rx_ready` is purely a sampled input; no combinational path from it to any output.

## Structure
- Shared package `uart_pkg`, also used by the transmitter:
  - `UART_CLKS_PER_BIT = 2604`;
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t`.
- One sub-module, `sync_fall_det`: 2-flop synchroniser plus `rxd_prev`; outputs `rxd_s` and `fall`; reset value 1.
- Remainder (FSM, counters, shift register, holding register) in `uart_rx`: roughly 150–200 lines.

## Test plan
- Pin drives 0x41 (8N1, 2604 clocks/bit), `rx_ready`=1:
  - `rx_valid` pulses 1 cycle with `rx_data`=0x41 and `led`=0x41;
  - `frame_err`=0, `overrun`=0.
- 26 back-to-back bytes 0x41..0x5A, no idle gap, `rx_ready`=1: all 26 delivered in order; no errors.
- 0x55 sent with stop bit forced 0:
  - `frame_err` pulses once; `rx_valid` stays 0;
  - line held low 10 bit times → no further activity;
  - line released, then 0x42 → 0x42 delivered.
- Low glitch of 500 clocks on idle line: FSM returns to `IDLE`; no `rx_valid`, no `frame_err`.
- Overrun:
  - send 0x10 with `rx_ready`=0, then 0x20 → `overrun`=1 and `rx_data` stays 0x10;
  - assert `rx_ready` → 0x10 consumed and `rx_valid` falls; `overrun` remains 1.
- `reset` asserted mid-frame (during `DATA`, `bit_idx`=4):
  - next cycle: all outputs at reset values;
  - subsequent 0x7E frame received correctly.
